// File: rtl/fifo_drain_ctrl_if.sv
// Valid/ready byte stream leaving the fifo drain controller.
// Signals: m_data (payload), m_valid (source), m_ready (sink).
interface fifo_drain_ctrl_if #(
  parameter int DW = 8
);
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// Reader-side fifo controller: bursts rd_en into a 3-deep skid buffer,
// forwards words on stream m; ports clk/reset/start/burst_len/fifo_*/busy/done/rd_count.
module fifo_drain_ctrl #(
  parameter int DW    = 8,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             fifo_empty,
  input  logic [DW-1:0]    fifo_dout,
  output logic             fifo_rd_en,
  fifo_drain_ctrl_if.master m,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] rd_count
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    DONE
  } state_t;

  localparam logic [LEN_W-1:0] ONE = 1;

  state_t state, state_n;

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic [1:0]       occ;
  logic [1:0]       wp;
  logic [1:0]       rp;
  logic             inflight;
  logic [DW-1:0]    buf_q [3];

  logic       push;
  logic       pop;
  logic       more;
  logic [2:0] fill;

  assign push = inflight;
  assign pop  = m.m_valid && m.m_ready;

  assign m.m_valid = (occ != 2'd0);
  assign m.m_data  = buf_q[rp];

  // Reserve buffer space for reads already in flight.
  assign fill = {1'b0, occ} + {2'b00, inflight};
  assign more = (len_q == '0) || (issued < len_q);

  assign fifo_rd_en = (state == DRAIN)
                   && !fifo_empty
                   && (fill < 3'd3)
                   && more;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_n = DRAIN;
      end
      DRAIN: begin
        if (len_q != '0) begin
          if (issued == len_q)
            state_n = FLUSH;
        end else if (fifo_empty && !inflight) begin
          state_n = FLUSH;
        end
      end
      FLUSH: begin
        if (occ == 2'd0 && !inflight)
          state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      len_q    <= '0;
      issued   <= '0;
      rd_count <= '0;
      occ      <= 2'd0;
      wp       <= 2'd0;
      rp       <= 2'd0;
      inflight <= 1'b0;
      for (int i = 0; i < 3; i++)
        buf_q[i] <= '0;
    end else begin
      state    <= state_n;
      inflight <= fifo_rd_en;

      if (state == IDLE && start) begin
        len_q    <= burst_len;
        issued   <= '0;
        rd_count <= '0;
      end else begin
        if (fifo_rd_en)
          issued <= issued + ONE;
        if (pop && rd_count != '1)
          rd_count <= rd_count + ONE;
      end

      if (push) begin
        buf_q[wp] <= fifo_dout;
        wp <= (wp == 2'd2) ? 2'd0 : wp + 2'd1;
      end

      if (pop)
        rp <= (rp == 2'd2) ? 2'd0 : rp + 2'd1;

      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule
